// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch types and constants for the RV32I core.
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {IDLE, RUN, ERROR} fetch_state_t;
endpackage

// File: rtl/fetch_queue2.sv
// fetch_queue2: 2-entry {pc, instr} FIFO whose head registers drive decode directly.
module fetch_queue2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] in_pc,
  input  logic [W-1:0] in_instr,
  output logic [1:0]   count,
  output logic [W-1:0] head_pc,
  output logic [W-1:0] head_instr
);
  logic [W-1:0] tail_pc, tail_instr;
  logic use_tail, take_in, to_tail;
  // Head only changes on pop or when an empty queue is filled, so it stays stable while stalled.
  assign use_tail = pop && count == 2'd2;
  assign take_in = push && (count == 2'd0 || (count == 2'd1 && pop));
  assign to_tail = push && !take_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      head_pc <= '0;
      head_instr <= '0;
      tail_pc <= '0;
      tail_instr <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (use_tail) begin
        head_pc <= tail_pc;
        head_instr <= tail_instr;
      end else if (take_in) begin
        head_pc <= in_pc;
        head_instr <= in_instr;
      end
      if (to_tail) begin
        tail_pc <= in_pc;
        tail_instr <= in_instr;
      end
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and sync-read imem fetcher with 2-deep buffer, redirect and squash.
module instr_fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0004
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_word,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready,
  output logic            fetch_error
);
  import rv32i_pkg::*;
  fetch_state_t state, state_n;
  logic inflight, issue, pop, push, misaligned;
  logic [XLEN-1:0] inflight_pc;
  logic [1:0] count;
  assign pop = out_valid && out_ready;
  assign push = inflight && !redirect_valid;
  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign out_valid = count != 2'd0;
  assign fetch_error = state == ERROR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // Occupancy counts the in-flight word so the queue can never overflow when it returns.
  always_comb begin
    state_n = state;
    issue = 1'b0;
    state_n = redirect_valid ? (misaligned ? ERROR : (fetch_en ? RUN : IDLE))
            : state == ERROR ? ERROR : (fetch_en ? RUN : IDLE);
    issue = state == RUN && fetch_en && !redirect_valid &&
            (3'(count) + 3'(inflight)) < (3'd2 + 3'(pop));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= imem_addr;
      if (redirect_valid && !misaligned) imem_addr <= redirect_pc;
      else if (issue) imem_addr <= imem_addr + XLEN'(INSTR_BYTES);
    end
  end
  fetch_queue2 #(.W(XLEN)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .in_pc(inflight_pc),
    .in_instr(imem_word),
    .count(count),
    .head_pc(out_pc),
    .head_instr(out_instr)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch streaming, stall, redirect, error, wrap and reset.
module tb_instr_fetch_unit;
  logic clk, rst, fetch_en, redirect_valid, out_valid, out_ready, fetch_error;
  logic [31:0] imem_addr, imem_word, redirect_pc, out_pc, out_instr;
  int errs = 0;
  int checks = 0;
  instr_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr),
    .imem_word(imem_word),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready),
    .fetch_error(fetch_error)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'd4 ? 32'h00100093 : a == 32'd8 ? 32'h00200113 :
           a == 32'd12 ? 32'h00300193 : a == 32'd16 ? 32'h00400213 : 32'h0;
  endfunction
  always #5 clk = ~clk;
  always_ff @(posedge clk) imem_word <= mem_word(imem_addr);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, instr);
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 8) begin
      step;
      n++;
    end
    check({tag, "_first_valid"}, 32'(out_valid), 32'd1);
  endtask
  task automatic do_reset;
    rst = 1;
    redirect_valid = 0;
    fetch_en = 1;
    out_ready = 1;
    step;
    step;
    rst = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    clk = 0; rst = 1; fetch_en = 1; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_addr", imem_addr, 32'd4);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_err", 32'(fetch_error), 32'd0);
    rst = 0;
    // streaming
    wait_valid("t1");
    check("t1_addr", imem_addr, 32'd12);
    expect_out("t1_a", 32'd4, 32'h00100093);
    step; expect_out("t1_b", 32'd8, 32'h00200113);
    step; expect_out("t1_c", 32'd12, 32'h00300193);
    step; expect_out("t1_d", 32'd16, 32'h00400213);
    // stall with out_ready low
    do_reset;
    wait_valid("t2");
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step;
      expect_out("t2_hold", 32'd4, 32'h00100093);
      check("t2_addr", imem_addr, 32'd12);
    end
    out_ready = 1;
    step; expect_out("t2_a", 32'd8, 32'h00200113);
    step; expect_out("t2_b", 32'd12, 32'h00300193);
    step; expect_out("t2_c", 32'd16, 32'h00400213);
    // fetch_en dropped and restored
    do_reset;
    wait_valid("t5");
    fetch_en = 0;
    step; expect_out("t5_drain", 32'd8, 32'h00200113);
    check("t5_addr", imem_addr, 32'd12);
    step; check("t5_empty1", 32'(out_valid), 32'd0);
    step; check("t5_empty2", 32'(out_valid), 32'd0);
    check("t5_addr_hold", imem_addr, 32'd12);
    fetch_en = 1;
    step; check("t5_run", 32'(out_valid), 32'd0);
    step; check("t5_iss", 32'(out_valid), 32'd0);
    check("t5_addr_iss", imem_addr, 32'd16);
    step; expect_out("t5_a", 32'd12, 32'h00300193);
    step; expect_out("t5_b", 32'd16, 32'h00400213);
    // redirect squashing in-flight fetch of 8
    do_reset;
    wait_valid("t3");
    redirect_valid = 1; redirect_pc = 32'd12;
    step; redirect_valid = 0;
    check("t3_flush", 32'(out_valid), 32'd0);
    check("t3_addr", imem_addr, 32'd12);
    step; check("t3_gap", 32'(out_valid), 32'd0);
    check("t3_addr2", imem_addr, 32'd16);
    step; expect_out("t3_a", 32'd12, 32'h00300193);
    step; expect_out("t3_b", 32'd16, 32'h00400213);
    // misaligned redirect then recovery
    redirect_valid = 1; redirect_pc = 32'd6;
    step; redirect_valid = 0;
    check("t4_err", 32'(fetch_error), 32'd1);
    check("t4_flush", 32'(out_valid), 32'd0);
    step; step;
    check("t4_err_sticky", 32'(fetch_error), 32'd1);
    check("t4_noissue", 32'(out_valid), 32'd0);
    redirect_valid = 1; redirect_pc = 32'd16;
    step; redirect_valid = 0;
    check("t4_clr", 32'(fetch_error), 32'd0);
    check("t4_addr", imem_addr, 32'd16);
    check("t4_gap0", 32'(out_valid), 32'd0);
    step; check("t4_gap1", 32'(out_valid), 32'd0);
    step; expect_out("t4_a", 32'd16, 32'h00400213);
    // address wrap
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step; redirect_valid = 0;
    check("t6_addr", imem_addr, 32'hFFFF_FFFC);
    check("t6_flush", 32'(out_valid), 32'd0);
    step; check("t6_wrap_addr", imem_addr, 32'd0);
    step; expect_out("t6_a", 32'hFFFF_FFFC, 32'h0);
    step; expect_out("t6_b", 32'd0, 32'h0);
    check("t6_addr8", imem_addr, 32'd8);
    step; expect_out("t6_c", 32'd4, 32'h00100093);
    // asynchronous reset mid-stream
    rst = 1;
    #1;
    check("t7_addr", imem_addr, 32'd4);
    check("t7_valid", 32'(out_valid), 32'd0);
    check("t7_pc", out_pc, 32'd0);
    check("t7_instr", out_instr, 32'd0);
    check("t7_err", 32'(fetch_error), 32'd0);
    @(negedge clk);
    step;
    rst = 0;
    wait_valid("t7");
    expect_out("t7_a", 32'd4, 32'h00100093);
    step; expect_out("t7_b", 32'd8, 32'h00200113);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
